mem_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the Harvard memory data port; the only master of dp_address/writedata/byteenable/read_dp/write_dp.
- Accepts one CPU load/store request at a time over a valid/ready handshake.
- Word-aligns the address, builds byte enables and lane-shifted write data, and honours memory stall.
- Returns lane-extracted, sign/zero-extended load data over a valid/ready response handshake.

---
 rtl/mem_lsu.sv | 206 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit in front of the Harvard data port: one request at a time, lane steering and load extension.
// Optional LSU_UNALIGNED_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
module mem_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dp_address,
    output logic [DATA_W-1:0] writedata,
    output logic [DATA_W/8-1:0] byteenable,
    output logic              read_dp,
    output logic              write_dp,
    input  logic [DATA_W-1:0] dp_readdata,
    input  logic              stall
);

    localparam int unsigned BeW = DATA_W / 8;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [BeW-1:0]    be_q;
    logic [DATA_W-1:0] wd_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              signed_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;

    // Decoded view of the incoming request; reserved size 3 behaves as a word.
    logic [1:0]        size_n;
    logic [1:0]        off_n;
    logic [BeW-1:0]    be_n;
    logic [DATA_W-1:0] wd_n;
    logic [ADDR_W-1:0] addr_n;

    assign size_n = (req_size == 2'd3) ? SizeWord : req_size;
    assign addr_n = {req_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        off_n = 2'b00;
        be_n  = '1;
        wd_n  = req_wdata;
        case (size_n)
            SizeByte: begin
                off_n = req_addr[1:0];
                be_n  = BeW'(1) << req_addr[1:0];
                wd_n  = {4{req_wdata[7:0]}};
            end
            SizeHalf: begin
                off_n = {req_addr[1], 1'b0};
                be_n  = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_n  = {2{req_wdata[15:0]}};
            end
            default: begin
                off_n = 2'b00;
                be_n  = '1;
                wd_n  = req_wdata;
            end
        endcase
    end

`ifdef LSU_UNALIGNED_TRAP_EN
    logic misaligned;
    logic err_q, err_d;

    assign misaligned = ((size_n == SizeHalf) && req_addr[0]) ||
                        ((size_n == SizeWord) && (req_addr[1:0] != 2'b00));
    assign resp_err   = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Lane extraction from the raw memory word, using the registered request.
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_val;

    assign lane_byte = dp_readdata[{off_q, 3'b000} +: 8];
    assign lane_half = off_q[1] ? dp_readdata[31:16] : dp_readdata[15:0];

    always_comb begin
        load_val = dp_readdata;
        case (size_q)
            SizeByte: load_val = {{(DATA_W-8){signed_q & lane_byte[7]}}, lane_byte};
            SizeHalf: load_val = {{(DATA_W-16){signed_q & lane_half[15]}}, lane_half};
            default:  load_val = dp_readdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        accept     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        read_dp    = 1'b0;
        write_dp   = 1'b0;
        dp_address = '0;
        writedata  = '0;
        byteenable = '0;
`ifdef LSU_UNALIGNED_TRAP_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            StAccess: begin
                read_dp    = ~we_q;
                write_dp   = we_q;
                dp_address = addr_q;
                writedata  = wd_q;
                byteenable = be_q;
                if (!stall) begin
                    rdata_d = we_q ? '0 : load_val;
                    state_d = StResp;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
                if (resp_ready) begin
                    accept  = req_valid;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d = StAccess;
`ifdef LSU_UNALIGNED_TRAP_EN
            err_d = misaligned;
            // A trapped request never touches memory and answers with zero data.
            if (misaligned) begin
                state_d = StResp;
                rdata_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            be_q     <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            size_q   <= SizeByte;
            off_q    <= 2'b00;
            signed_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q   <= addr_n;
                be_q     <= be_n;
                wd_q     <= wd_n;
                we_q     <= req_we;
                size_q   <= size_n;
                off_q    <= off_n;
                signed_q <= req_signed;
            end
        end
    end

`ifdef LSU_UNALIGNED_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: table of directed load/store vectors plus stall,
// back-pressure, misaligned-access and mid-access reset sequences.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] dp_address, writedata, dp_readdata;
    logic [3:0]  byteenable;
    logic        read_dp, write_dp, stall;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_edges = 0;
    int wr_commits = 0;

    logic [31:0] mem [0:15] = '{default: 32'h0};
    logic [31:0] be_mask;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .dp_address  (dp_address),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .read_dp     (read_dp),
        .write_dp    (write_dp),
        .dp_readdata (dp_readdata),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    // Memory peripheral: disabled lanes read 0, data is junk while stalled.
    assign be_mask = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
    assign dp_readdata = !read_dp ? 32'h0 :
                         stall    ? 32'hBAD0BAD0 : (mem[dp_address[5:2]] & be_mask);

    always @(posedge clk) begin
        if (write_dp) begin
            wr_edges <= wr_edges + 1;
            if (!stall) begin
                wr_commits <= wr_commits + 1;
                for (int k = 0; k < 4; k++)
                    if (byteenable[k]) mem[dp_address[5:2]][8*k +: 8] <= writedata[8*k +: 8];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int c0;
        @(negedge clk);
        check($sformatf("v%0d_req_ready", i), {31'b0, req_ready}, 32'd1);
        issue(v.we, v.size, v.sgn, v.addr, v.wdata);
        c0 = wr_commits;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check($sformatf("v%0d_strobes", i), {30'b0, read_dp, write_dp}, {30'b0, ~v.we, v.we});
        check($sformatf("v%0d_addr", i), dp_address, v.exp_addr);
        check($sformatf("v%0d_be", i), {28'b0, byteenable}, {28'b0, v.exp_be});
        if (v.we) check($sformatf("v%0d_wdata", i), writedata, v.exp_wd);
        check($sformatf("v%0d_early_valid", i), {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_resp_valid", i), {31'b0, resp_valid}, 32'd1);
        check($sformatf("v%0d_rdata", i), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", i), {31'b0, resp_err}, 32'd0);
        check($sformatf("v%0d_strobes_off", i), {30'b0, read_dp, write_dp}, 32'd0);
        if (v.we) check($sformatf("v%0d_commits", i), wr_commits - c0, 32'd1);
        finish_resp();
        check($sformatf("v%0d_valid_drop", i), {31'b0, resp_valid}, 32'd0);
    endtask

    // Misaligned access: trapped when the feature is on, force-aligned otherwise.
    task automatic run_mis(input string name, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_rdata);
        @(negedge clk);
        issue(1'b0, size, sgn, addr, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef LSU_UNALIGNED_TRAP_EN
        check({name, "_trap_valid"}, {31'b0, resp_valid}, 32'd1);
        check({name, "_trap_err"}, {31'b0, resp_err}, 32'd1);
        check({name, "_trap_rdata"}, resp_rdata, 32'h0);
        check({name, "_trap_no_read"}, {30'b0, read_dp, write_dp}, 32'd0);
`else
        check({name, "_read"}, {31'b0, read_dp}, 32'd1);
        check({name, "_addr"}, dp_address, exp_addr);
        check({name, "_be"}, {28'b0, byteenable}, {28'b0, exp_be});
        @(posedge clk); #1;
        check({name, "_valid"}, {31'b0, resp_valid}, 32'd1);
        check({name, "_rdata"}, resp_rdata, exp_rdata);
        check({name, "_err"}, {31'b0, resp_err}, 32'd0);
`endif
        finish_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, c0;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; stall = 1'b0;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h10, 4'hF, 32'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 32'h10, 4'h8, 32'hA5A5A5A5, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h10, 4'h8, 32'h0, 32'hFFFFFFA5};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h10, 4'h8, 32'h0, 32'h000000A5};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80017FFF, 32'h10, 4'hF, 32'h80017FFF, 32'h0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h10, 4'hC, 32'h0, 32'hFFFF8001};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h10, 4'h3, 32'h0, 32'h00007FFF};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h16, 32'h1234ABCD, 32'h14, 4'hC, 32'hABCDABCD, 32'h0};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        32'h14, 4'hF, 32'h0, 32'hABCD0000};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 32'h17, 32'h0,        32'h14, 4'h8, 32'h0, 32'hFFFFFFAB};
        vecs[11] = '{1'b1, 2'd0, 1'b0, 32'h14, 32'h0000007F, 32'h14, 4'h1, 32'h7F7F7F7F, 32'h0};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h14, 32'h0,        32'h14, 4'h1, 32'h0, 32'h0000007F};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 32'h16, 32'h0,        32'h14, 4'hC, 32'h0, 32'hFFFFABCD};
        vecs[14] = '{1'b0, 2'd3, 1'b0, 32'h14, 32'h0,        32'h14, 4'hF, 32'h0, 32'hABCD007F};
        vecs[15] = '{1'b0, 2'd2, 1'b1, 32'h14, 32'h0,        32'h14, 4'hF, 32'h0, 32'hABCD007F};
        vecs[16] = '{1'b0, 2'd1, 1'b0, 32'h14, 32'h0,        32'h14, 4'h3, 32'h0, 32'h0000007F};

        // Reset state
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_dp_address", dp_address, 32'h0);
        check("rst_writedata", writedata, 32'h0);
        check("rst_byteenable", {28'b0, byteenable}, 32'h0);
        check("rst_strobes", {30'b0, read_dp, write_dp}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Load held by three stall edges: four ACCESS cycles, single capture.
        @(negedge clk);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        stall = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall_ld_read_c%0d", c), {31'b0, read_dp}, 32'd1);
            check($sformatf("stall_ld_addr_c%0d", c), dp_address, 32'h10);
            check($sformatf("stall_ld_nvalid_c%0d", c), {31'b0, resp_valid}, 32'd0);
            if (c == 3) stall = 1'b0;
            @(posedge clk); #1;
        end
        check("stall_ld_valid", {31'b0, resp_valid}, 32'd1);
        check("stall_ld_rdata", resp_rdata, 32'h80017FFF);
        finish_resp();

        // Store held by two stall edges commits exactly once.
        @(negedge clk);
        issue(1'b1, 2'd2, 1'b0, 32'h18, 32'hCAFEF00D);
        stall = 1'b1;
        e0 = wr_edges;
        c0 = wr_commits;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall_st_write_c%0d", c), {31'b0, write_dp}, 32'd1);
            check($sformatf("stall_st_wd_c%0d", c), writedata, 32'hCAFEF00D);
            if (c == 2) stall = 1'b0;
            @(posedge clk); #1;
        end
        check("stall_st_valid", {31'b0, resp_valid}, 32'd1);
        check("stall_st_rdata", resp_rdata, 32'h0);
        check("stall_st_held_edges", wr_edges - e0, 32'd3);
        check("stall_st_commits", wr_commits - c0, 32'd1);
        finish_resp();
        check("stall_st_mem", mem[6], 32'hCAFEF00D);

        // Response back-pressure with the next request waiting.
        @(negedge clk);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("bp_valid_c%0d", c), {31'b0, resp_valid}, 32'd1);
            check($sformatf("bp_rdata_c%0d", c), resp_rdata, 32'h80017FFF);
            check($sformatf("bp_req_ready_c%0d", c), {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        check("bp_req_ready_on_consume", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        check("bp_next_read", {31'b0, read_dp}, 32'd1);
        check("bp_next_be", {28'b0, byteenable}, 32'h3);
        check("bp_next_nvalid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("bp_next_valid", {31'b0, resp_valid}, 32'd1);
        check("bp_next_rdata", resp_rdata, 32'h00007FFF);
        finish_resp();

        run_mis("mis_lw11", 2'd2, 1'b0, 32'h11, 32'h10, 4'hF, 32'h80017FFF);
        run_mis("mis_lh13", 2'd1, 1'b1, 32'h13, 32'h10, 4'hC, 32'hFFFF8001);

        // Asynchronous reset in the middle of a store.
        @(negedge clk);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111);
        c0 = wr_commits;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mid_write_on", {31'b0, write_dp}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_strobes", {30'b0, read_dp, write_dp}, 32'd0);
        check("rst_mid_be", {28'b0, byteenable}, 32'h0);
        check("rst_mid_addr", dp_address, 32'h0);
        check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_idle_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_no_commit", wr_commits - c0, 32'd0);
        run_vec(99, '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h20, 4'hF, 32'h0, 32'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
